// File: rtl/pb_pkg.sv
// Shared types and defaults for the two-channel pushbutton conditioner.
package pb_pkg;

    localparam int unsigned DEB_CYCLES_DEF   = 10;
    localparam int unsigned CNT_W_DEF        = 8;
    localparam int unsigned STUCK_CYCLES_DEF = 2500;
    localparam int unsigned HOLD_W           = 16;

    // Channel indices into the stuck vector
    localparam int unsigned L = 1;
    localparam int unsigned R = 0;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } pb_state_t;

endpackage

// File: rtl/pb_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with counter, registered level/pulse.
// Optional stuck-button hold counter under PB_STUCK_DETECT_EN.
module pb_channel
    import pb_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic stuck
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    pb_state_t        state;
    pb_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             level_nxt;
    logic             stuck_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Any sample disagreeing with the candidate level restarts the count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);

`ifdef PB_STUCK_DETECT_EN
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;

    // Hold time accumulates while pressed, saturates at the stuck threshold
    always_comb begin
        hold_nxt = hold;
        if (state_nxt == IDLE) begin
            hold_nxt = '0;
        end else if (((state == PRESSED) || (state == RELEASE_WAIT)) &&
                     (hold < HOLD_W'(STUCK_CYCLES))) begin
            hold_nxt = hold + HOLD_W'(1);
        end
    end

    assign stuck_nxt = (hold_nxt == HOLD_W'(STUCK_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold  <= '0;
            stuck <= 1'b0;
        end else begin
            hold  <= hold_nxt;
            stuck <= stuck_nxt;
        end
    end
`else
    assign stuck_nxt = 1'b0;
    assign stuck     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            level <= level_nxt && !stuck_nxt;
            press <= press_nxt && !stuck_nxt;
        end
    end

endmodule

// File: rtl/pb_debounce.sv
// Two-channel pushbutton conditioner feeding the game top; wiring only.
// Optional stuck detection enabled by defining PB_STUCK_DETECT_EN.
module pb_debounce
    import pb_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl_raw,
    input  logic       pbr_raw,
    output logic       pbl,
    output logic       pbr,
    output logic       pbl_press,
    output logic       pbr_press,
    output logic [1:0] stuck
);

    pb_channel #(
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_left (
        .clk  (clk),
        .rst  (rst),
        .raw  (pbl_raw),
        .level(pbl),
        .press(pbl_press),
        .stuck(stuck[L])
    );

    pb_channel #(
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_right (
        .clk  (clk),
        .rst  (rst),
        .raw  (pbr_raw),
        .level(pbr),
        .press(pbr_press),
        .stuck(stuck[R])
    );

endmodule

// File: doc/pb_debounce.md
Name: pb_debounce

Overview:
- Two-channel pushbutton conditioner directly upstream of the tug-of-war top: produces the clean `pbl`/`pbr` levels that top consumes.
- Each raw board input is:
  - synchronised (2 flops);
  - debounced by a per-channel counter FSM;
  - emitted as a stable level plus a one-cycle press pulse.
- Runs on the divided 500 Hz game clock `clk`, so one debounce tick = 2 ms.

Parameters:
- DEB_CYCLES, 10, consecutive stable samples required to accept a press or a release (10 = 20 ms at 500 Hz); legal range 2..255.
- CNT_W, 8, width of each debounce counter; requires DEB_CYCLES < 2**CNT_W.
- STUCK_CYCLES, 2500, hold time in cycles that marks a button stuck (5 s); used only with PB_STUCK_DETECT_EN; 16-bit counter.

Ports:
- clk  in  1  game clock (500 Hz)
- rst  in  1  asynchronous, active-low reset
- pbl_raw  in  1  raw left button, asynchronous, active-high
- pbr_raw  in  1  raw right button, asynchronous, active-high
- pbl  out  1  debounced left level
- pbr  out  1  debounced right level
- pbl_press  out  1  one-cycle pulse on accepted left press
- pbr_press  out  1  one-cycle pulse on accepted right press
- stuck  out  2  [1]=left stuck, [0]=right stuck; tied 0 without PB_STUCK_DETECT_EN

Behaviour:
- Reset (rst=0, asynchronous):
  - all synchroniser flops, counters and FSMs clear;
  - FSM enters IDLE;
  - pbl = pbr = 0, pbl_press = pbr_press = 0, stuck = 0.
- Release: synchronous; the first evaluated edge follows rst rising.
- Synchroniser: raw → s1 → s2. All FSM logic sees s2 only; 2-cycle input latency.
- Per-channel FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: out=0. s2=1 → PRESS_WAIT, cnt=1.
  - PRESS_WAIT: out=0.
    - s2=1 and cnt==DEB_CYCLES-1 → PRESSED; assert press pulse that same edge.
    - s2=1 otherwise → cnt+1.
    - s2=0 → IDLE, cnt=0 (any bounce restarts the count).
  - PRESSED: out=1. s2=0 → RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: out=1.
    - s2=0 and cnt==DEB_CYCLES-1 → IDLE.
    - s2=0 otherwise → cnt+1.
    - s2=1 → PRESSED, cnt=0. No new press pulse.
- Latency: a clean press asserts `out` and the press pulse DEB_CYCLES+2 edges after the raw rise. A clean release deasserts `out` DEB_CYCLES+2 edges after the raw fall.
- Outputs are registered: level and pulse come from flops, never combinational from s2.
- Press pulse: exactly one cycle per accepted press, regardless of hold length.
- Counter: saturating compare, never wraps; cnt never exceeds DEB_CYCLES-1.
- Channels are fully independent. Simultaneous presses on both produce pulses in the same cycle; tie resolution belongs downstream.
- Reset mid-debounce abandons the count. The button must then be seen stable for a full DEB_CYCLES after reset release.

Optional Feature:
- PB_STUCK_DETECT_EN defined:
  - a per-channel 16-bit hold counter increments while in PRESSED or RELEASE_WAIT and clears in IDLE;
  - on reaching STUCK_CYCLES it saturates and sets stuck[ch]=1;
  - while stuck[ch]=1, the corresponding out is forced to 0 and no press pulse is emitted;
  - stuck[ch] clears when the FSM returns to IDLE (genuine debounced release) or on reset.
- Undefined: no hold counters are synthesised; stuck = 2'b00 constant.

Decomposition:
- Shared package `pb_pkg`:
  - 2-bit FSM state encoding: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3;
  - default DEB_CYCLES/STUCK_CYCLES constants;
  - channel index constants L=1, R=0.
- Sub-module `pb_channel`: one synchroniser + FSM + counter (+ optional hold counter). Instantiated twice by pb_debounce, which only wires ports.

Test Plan:
- Reset: assert rst=0 mid-run with a button held → all outputs 0 immediately (asynchronous). After release, a held button gives pbl=1 exactly 12 edges later (DEB_CYCLES=10).
- Clean press: pbl_raw 0→1 held 30 cycles → pbl_press high for exactly 1 cycle at edge 12 and pbl=1 from edge 12. pbl_raw falls → pbl=0 at edge 12 after the fall.
- Bounce: pbr_raw toggles 1,0,1,1,0 then held 1 → no pulse during the toggles; a single pbr_press 12 edges after the final rise.
- Release glitch: while pbl=1, pbl_raw low for 3 cycles then high → pbl stays 1, no extra pbl_press.
- Simultaneous: both raw rise on the same edge → pbl_press and pbr_press high in the same cycle, once each.
- PB_STUCK_DETECT_EN, STUCK_CYCLES=50: hold pbr_raw 100 cycles → stuck[0]=1 and pbr=0 after 50 cycles in PRESSED. Release → stuck[0]=0 once IDLE is reached. Without the macro, stuck stays 00 throughout.
